// File: rtl/asj_nco_phase_det.sv
// Vectoring-mode CORDIC phase detector: recovers phase, magnitude and phase
// increment from a signed sin/cos sample stream (inverse of the NCO datapath).
module asj_nco_phase_det #(
  parameter int unsigned mpr  = 13,
  parameter int unsigned pw   = 16,
  parameter int unsigned iter = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  in_valid,
  input  logic signed [mpr-1:0] fsin_i,
  input  logic signed [mpr-1:0] fcos_i,
  output logic [pw-1:0]         phase_o,
  output logic [mpr:0]          mag_o,
  output logic [pw-1:0]         phi_inc_o,
  output logic                  out_valid,
  output logic                  inc_valid
);

  localparam int unsigned W  = mpr + 2;
  localparam int unsigned WE = W + 1;
  localparam logic [pw-1:0] Z_Q1 = pw'(2 ** (pw - 2));
  localparam logic [pw-1:0] Z_Q3 = pw'(3 * (2 ** (pw - 2)));
  localparam logic signed [WE-1:0] MAG_MAX = WE'((2 ** (mpr + 1)) - 1);

  typedef logic [iter-1:0][pw-1:0] atan_tbl_t;

  // round(atan(2^-idx) * 2^pw / (2*pi)), evaluated at elaboration
  function automatic int atan_units(input int idx);
    real pi_c;
    real t;
    real term;
    real acc;
    real scale;
    pi_c  = 3.14159265358979323846;
    scale = 1.0;
    for (int k = 0; k < int'(pw); k++) scale = scale * 2.0;
    if (idx == 0) begin
      acc = pi_c / 4.0;
    end else begin
      t = 1.0;
      for (int k = 0; k < idx; k++) t = t / 2.0;
      acc  = 0.0;
      term = t;
      for (int k = 0; k < 30; k++) begin
        if ((k % 2) == 0) acc = acc + term / $itor(2 * k + 1);
        else              acc = acc - term / $itor(2 * k + 1);
        term = term * t * t;
      end
    end
    return $rtoi(acc * scale / (2.0 * pi_c) + 0.5);
  endfunction

  function automatic atan_tbl_t build_atan_tbl();
    atan_tbl_t tbl;
    for (int i = 0; i < int'(iter); i++) tbl[i] = pw'(atan_units(i));
    return tbl;
  endfunction

  localparam atan_tbl_t ATAN_TBL = build_atan_tbl();

  logic signed [W-1:0] w_x_in;
  logic signed [W-1:0] w_y_in;
  logic signed [W-1:0] w_x_pre;
  logic signed [W-1:0] w_y_pre;
  logic [pw-1:0]       w_z_pre;
  logic                w_zero_in;

  logic signed [W-1:0] r_x [iter+1];
  logic signed [W-1:0] r_y [iter+1];
  logic [pw-1:0]       r_z [iter+1];
  logic [iter:0]       r_vld;
  logic [iter:0]       r_zero;

  logic signed [W-1:0] w_x_nxt [iter];
  logic signed [W-1:0] w_y_nxt [iter];
  logic [pw-1:0]       w_z_nxt [iter];

  logic [pw-1:0]       w_phase;
  logic [mpr:0]        w_mag;
  logic signed [WE-1:0] w_x_ext;
  logic                r_have_prev;

  // Pre-rotation folds the left half-plane onto X>=0; widening absorbs -(-2^(mpr-1))
  always_comb begin
    w_x_in    = W'(fcos_i);
    w_y_in    = W'(fsin_i);
    w_x_pre   = w_x_in;
    w_y_pre   = w_y_in;
    w_z_pre   = '0;
    w_zero_in = (fcos_i == '0) && (fsin_i == '0);
    if (w_x_in[W-1]) begin
      if (!w_y_in[W-1]) begin
        w_x_pre = w_y_in;
        w_y_pre = -w_x_in;
        w_z_pre = Z_Q1;
      end else begin
        w_x_pre = -w_y_in;
        w_y_pre = w_x_in;
        w_z_pre = Z_Q3;
      end
    end
  end

  // Micro-rotations drive y toward zero; shifts use the pre-stage x and y
  always_comb begin
    for (int i = 0; i < int'(iter); i++) begin
      if (!r_y[i][W-1]) begin
        w_x_nxt[i] = r_x[i] + (r_y[i] >>> i);
        w_y_nxt[i] = r_y[i] - (r_x[i] >>> i);
        w_z_nxt[i] = r_z[i] + ATAN_TBL[i];
      end else begin
        w_x_nxt[i] = r_x[i] - (r_y[i] >>> i);
        w_y_nxt[i] = r_y[i] + (r_x[i] >>> i);
        w_z_nxt[i] = r_z[i] - ATAN_TBL[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= int'(iter); i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
        r_z[i] <= '0;
      end
      r_vld  <= '0;
      r_zero <= '0;
    end else if (clken) begin
      r_x[0]    <= w_x_pre;
      r_y[0]    <= w_y_pre;
      r_z[0]    <= w_z_pre;
      r_vld[0]  <= in_valid;
      r_zero[0] <= w_zero_in;
      for (int i = 0; i < int'(iter); i++) begin
        r_x[i+1]    <= w_x_nxt[i];
        r_y[i+1]    <= w_y_nxt[i];
        r_z[i+1]    <= w_z_nxt[i];
        r_vld[i+1]  <= r_vld[i];
        r_zero[i+1] <= r_zero[i];
      end
    end
  end

  // A (0,0) input never settles y, so its accumulated angle is forced to zero
  always_comb begin
    w_phase = r_zero[iter] ? '0 : r_z[iter];
    w_x_ext = WE'(r_x[iter]);
    if (w_x_ext > MAG_MAX) begin
      w_mag = '1;
    end else if (w_x_ext[WE-1]) begin
      w_mag = '0;
    end else begin
      w_mag = r_x[iter][mpr:0];
    end
  end

  // phase_o doubles as the previous-valid-phase register: it only loads on valid results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_o     <= '0;
      mag_o       <= '0;
      phi_inc_o   <= '0;
      out_valid   <= 1'b0;
      inc_valid   <= 1'b0;
      r_have_prev <= 1'b0;
    end else if (clken) begin
      out_valid <= r_vld[iter];
      inc_valid <= r_vld[iter] && r_have_prev;
      if (r_vld[iter]) begin
        phase_o     <= w_phase;
        mag_o       <= w_mag;
        phi_inc_o   <= w_phase - phase_o;
        r_have_prev <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_asj_nco_phase_det.sv
// Bench for asj_nco_phase_det: ideal atan2/hypot model with CORDIC tolerance,
// directed axis/boundary vectors, sample streams, clken gating, bubbles, reset.
module tb_asj_nco_phase_det;

  localparam int  MPR     = 13;
  localparam int  PW      = 16;
  localparam int  ITER    = 12;
  localparam int  DEPTH   = ITER + 2;
  localparam real PI      = 3.14159265358979323846;
  localparam real PH_TOL  = 12.0;
  localparam real MAG_TOL = 16.0;
  localparam real INC_TOL = 24.0;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  clken;
  logic                  in_valid;
  logic signed [MPR-1:0] fsin_i;
  logic signed [MPR-1:0] fcos_i;
  logic [PW-1:0]         phase_o;
  logic [MPR:0]          mag_o;
  logic [PW-1:0]         phi_inc_o;
  logic                  out_valid;
  logic                  inc_valid;

  int n_checks = 0;
  int n_fail   = 0;

  asj_nco_phase_det #(.mpr(MPR), .pw(PW), .iter(ITER)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .in_valid  (in_valid),
    .fsin_i    (fsin_i),
    .fcos_i    (fcos_i),
    .phase_o   (phase_o),
    .mag_o     (mag_o),
    .phi_inc_o (phi_inc_o),
    .out_valid (out_valid),
    .inc_valid (inc_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int x;
    int y;
  } samp_t;

  samp_t q[$];
  bit    m_valid     = 1'b0;
  bit    m_inc_valid = 1'b0;
  bit    m_have_prev = 1'b0;
  real   m_phase     = 0.0;
  real   m_mag       = 0.0;
  real   m_inc       = 0.0;
  real   m_prev      = 0.0;
  real   kgain       = 1.0;

  function automatic real wrap_units(input real v);
    real r;
    r = v;
    while (r >= 65536.0) r = r - 65536.0;
    while (r < 0.0) r = r + 65536.0;
    return r;
  endfunction

  function automatic real ideal_phase(input int x, input int y);
    if (x == 0 && y == 0) return 0.0;
    return wrap_units($atan2($itor(y), $itor(x)) * 65536.0 / (2.0 * PI));
  endfunction

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic int stream_ph(input int k);
    return (33280 + k * 1024) % 65536;
  endfunction

  function automatic int cos_s(input int ph);
    return rnd(4095.0 * $cos(2.0 * PI * $itor(ph) / 65536.0));
  endfunction

  function automatic int sin_s(input int ph);
    return rnd(4095.0 * $sin(2.0 * PI * $itor(ph) / 65536.0));
  endfunction

  // Model: each sample emerges DEPTH clken edges after capture
  always @(posedge clk or negedge reset_n) begin
    samp_t s;
    real   ph;
    if (!reset_n) begin
      q.delete();
      m_valid     = 1'b0;
      m_inc_valid = 1'b0;
      m_have_prev = 1'b0;
      m_phase     = 0.0;
      m_mag       = 0.0;
      m_inc       = 0.0;
      m_prev      = 0.0;
    end else if (clken) begin
      s.v = in_valid;
      s.x = int'(fcos_i);
      s.y = int'(fsin_i);
      q.push_back(s);
      m_valid     = 1'b0;
      m_inc_valid = 1'b0;
      if (q.size() == DEPTH) begin
        s = q.pop_front();
        if (s.v) begin
          ph          = ideal_phase(s.x, s.y);
          m_valid     = 1'b1;
          m_inc_valid = m_have_prev;
          m_have_prev = 1'b1;
          m_phase     = ph;
          m_mag       = kgain * $sqrt($itor(s.x) * $itor(s.x) + $itor(s.y) * $itor(s.y));
          m_inc       = wrap_units(ph - m_prev);
          m_prev      = ph;
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_near(input string name, input int act, input real exp,
                            input real tol, input bit circ);
    real d;
    n_checks++;
    d = $itor(act) - exp;
    if (circ) begin
      while (d >= 32768.0) d = d - 65536.0;
      while (d < -32768.0) d = d + 65536.0;
    end
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0.1f +- %0.1f at %0t", name, act, exp, tol, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled away from the active edge
  always @(negedge clk) begin
    check_bit("out_valid", out_valid, m_valid);
    check_bit("inc_valid", inc_valid, m_inc_valid);
    check_near("phase_o", int'(phase_o), m_phase, PH_TOL, 1'b1);
    check_near("mag_o", int'(mag_o), m_mag, MAG_TOL, 1'b0);
    check_near("phi_inc_o", int'(phi_inc_o), m_inc, INC_TOL, 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input int c, input int s, input bit ce);
    in_valid = v;
    fcos_i   = MPR'(c);
    fsin_i   = MPR'(s);
    clken    = ce;
  endtask

  task automatic flush(input int n);
    set_in(1'b0, 0, 0, 1'b1);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bit ce;
    int ax_c [3];
    int ax_s [3];
    real ax_p [3];
    real f;

    for (int i = 0; i < ITER; i++) begin
      f = 1.0;
      for (int j = 0; j < 2 * i; j++) f = f / 2.0;
      kgain = kgain * $sqrt(1.0 + f);
    end

    set_in(1'b0, 0, 0, 1'b1);
    repeat (3) tick();
    check_bit("reset out_valid", out_valid, 1'b0);
    check_bit("reset inc_valid", inc_valid, 1'b0);
    check_near("reset phase_o", int'(phase_o), 0.0, 0.0, 1'b0);
    check_near("reset mag_o", int'(mag_o), 0.0, 0.0, 1'b0);
    check_near("reset phi_inc_o", int'(phi_inc_o), 0.0, 0.0, 1'b0);
    reset_n = 1'b1;
    tick();

    // +X axis: latency and first/second result
    set_in(1'b1, 4095, 0, 1'b1);
    repeat (13) tick();
    check_bit("t1 out_valid before latency", out_valid, 1'b0);
    tick();
    check_bit("t1 out_valid at latency", out_valid, 1'b1);
    check_bit("t1 inc_valid first result", inc_valid, 1'b0);
    check_near("t1 phase_o", int'(phase_o), 0.0, 5.0, 1'b1);
    check_near("t1 mag_o", int'(mag_o), 6744.0, 8.0, 1'b0);
    tick();
    check_bit("t1 inc_valid second result", inc_valid, 1'b1);
    check_near("t1 phi_inc_o constant input", int'(phi_inc_o), 0.0, 0.0, 1'b1);

    // Remaining axes
    ax_c = '{0, -4095, 0};
    ax_s = '{4095, 0, -4095};
    ax_p = '{16384.0, 32768.0, 49152.0};
    for (int a = 0; a < 3; a++) begin
      set_in(1'b1, ax_c[a], ax_s[a], 1'b1);
      repeat (16) tick();
      check_near("t2 axis phase_o", int'(phase_o), ax_p[a], 5.0, 1'b1);
      check_near("t2 axis mag_o", int'(mag_o), 6744.0, 8.0, 1'b0);
    end

    // Zero input and full-scale negative boundaries
    set_in(1'b1, 0, 0, 1'b1);
    repeat (16) tick();
    check_bit("zero out_valid", out_valid, 1'b1);
    check_near("zero phase_o", int'(phase_o), 0.0, 0.0, 1'b0);
    check_near("zero mag_o", int'(mag_o), 0.0, 0.0, 1'b0);
    set_in(1'b1, -4096, -4096, 1'b1);
    repeat (16) tick();
    set_in(1'b1, -4096, 0, 1'b1);
    repeat (16) tick();
    set_in(1'b1, 0, -4096, 1'b1);
    repeat (16) tick();
    flush(16);

    // Stepped stream across the phase wrap
    for (int j = 0; j < 64; j++) begin
      set_in(1'b1, cos_s(stream_ph(j)), sin_s(stream_ph(j)), 1'b1);
      tick();
      if (j == 40) begin
        check_bit("t3 inc_valid", inc_valid, 1'b1);
        check_near("t3 phi_inc_o", int'(phi_inc_o), 1024.0, 16.0, 1'b1);
      end
    end
    flush(16);

    // Same stream with clken gated pseudo-randomly
    k = 0;
    while (k < 64) begin
      ce = 1'($urandom_range(0, 1));
      set_in(1'b1, cos_s(stream_ph(k)), sin_s(stream_ph(k)), ce);
      tick();
      if (ce) k++;
    end
    repeat (40) begin
      set_in(1'b0, 0, 0, 1'($urandom_range(0, 1)));
      tick();
    end
    flush(16);

    // Alternating bubbles
    for (int j = 0; j < 64; j++) begin
      set_in((j % 2) == 0, cos_s(stream_ph(j)), sin_s(stream_ph(j)), 1'b1);
      tick();
      if (j == 41) begin
        check_bit("t5 out_valid", out_valid, 1'b1);
        check_near("t5 phi_inc_o", int'(phi_inc_o), 2048.0, 16.0, 1'b1);
      end
      if (j == 42) begin
        check_bit("t5 bubble out_valid", out_valid, 1'b0);
        check_near("t5 bubble phase_o held", int'(phase_o), 61952.0, PH_TOL, 1'b1);
      end
    end
    flush(16);

    // Reset pulse mid-stream
    for (int j = 0; j < 30; j++) begin
      set_in(1'b1, cos_s(stream_ph(j)), sin_s(stream_ph(j)), 1'b1);
      tick();
    end
    check_bit("t6 out_valid before reset", out_valid, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check_bit("t6 async out_valid", out_valid, 1'b0);
    check_bit("t6 async inc_valid", inc_valid, 1'b0);
    check_near("t6 async phase_o", int'(phase_o), 0.0, 0.0, 1'b0);
    check_near("t6 async mag_o", int'(mag_o), 0.0, 0.0, 1'b0);
    check_near("t6 async phi_inc_o", int'(phi_inc_o), 0.0, 0.0, 1'b0);
    set_in(1'b1, cos_s(stream_ph(30)), sin_s(stream_ph(30)), 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int j = 0; j < 16; j++) begin
      set_in(1'b1, cos_s(stream_ph(30 + j)), sin_s(stream_ph(30 + j)), 1'b1);
      tick();
      if (j == 12) check_bit("t6 out_valid before latency", out_valid, 1'b0);
      if (j == 13) begin
        check_bit("t6 out_valid at latency", out_valid, 1'b1);
        check_bit("t6 inc_valid first result", inc_valid, 1'b0);
      end
      if (j == 14) check_bit("t6 inc_valid second result", inc_valid, 1'b1);
    end
    flush(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
